// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_arb_pkg
// Purpose : Shared types and helpers for the packet arbiter/mux.
//           - arb_state_t : arbiter FSM states (IDLE, LOCK)
//           - idx_w()     : index width for a given port count
// Revision: 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of an index into 'ports' entries; never less than one bit.
  function automatic int idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module  : priority_encoder
// Purpose : Returns the index of the highest-priority set request bit.
// Ports   : req_i   [N-1:0]     request vector
//           found_o              any request set
//           idx_o   [idx_w(N)]   winning index (0 when nothing is set)
// Revision: 1.0 - initial release
// ============================================================================
module priority_encoder
  import axis_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter bit LSB_HIGH = 1'b1
) (
  input  logic [N-1:0]          req_i,
  output logic                  found_o,
  output logic [idx_w(N)-1:0]   idx_o
);

  localparam int c_idx_w = idx_w(N);

  // Scan from the lowest-priority end so the last hit written is the winner.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    if (LSB_HIGH) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = c_idx_w'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) idx_o = c_idx_w'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_packet_arb_mux.sv
`default_nettype none
// ============================================================================
// Module  : axis_packet_arb_mux
// Purpose : Packet-granular arbiter sharing one registered AXI-Stream output
//           among PORTS requesters (round-robin or fixed priority).
// Ports   : clk, rstn (async active-low)
//           s_axis_tdata/tvalid/tlast [per port], s_axis_tready [per port]
//           m_axis_tdata/tvalid/tlast/tid (registered), m_axis_tready
//           busy : high while a grant is locked
// Revision: 1.0 - initial release
// ============================================================================
module axis_packet_arb_mux
  import axis_arb_pkg::*;
#(
  parameter int PORTS       = 4,
  parameter int DATA_W      = 32,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit LSB_HIGH    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]          s_axis_tvalid,
  input  logic [PORTS-1:0]          s_axis_tlast,
  output logic [PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [idx_w(PORTS)-1:0]   m_axis_tid,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam int               c_idx_w = idx_w(PORTS);
  localparam logic [PORTS-1:0] c_one   = PORTS'(1);

  arb_state_t             state_q;
  logic [PORTS-1:0]       grant_q;
  logic [c_idx_w-1:0]     grant_idx_q;
  logic [PORTS-1:0]       mask_q;
  logic [PORTS-1:0]       mask_d;
  logic [DATA_W-1:0]      m_tdata_q;
  logic                   m_tvalid_q;
  logic                   m_tlast_q;
  logic [c_idx_w-1:0]     m_tid_q;

  logic [DATA_W-1:0]      w_data [PORTS];
  logic                   w_any_found;
  logic [c_idx_w-1:0]     w_any_idx;
  logic                   w_msk_found;
  logic [c_idx_w-1:0]     w_msk_idx;
  logic [c_idx_w-1:0]     w_win_idx;
  logic                   w_out_ready;
  logic                   w_accept;
  logic                   w_accept_last;

  for (genvar p = 0; p < PORTS; p++) begin : g_unpack
    assign w_data[p] = s_axis_tdata[p*DATA_W +: DATA_W];
  end

  priority_encoder #(.N(PORTS), .LSB_HIGH(LSB_HIGH)) u_pe_all (
    .req_i   (s_axis_tvalid),
    .found_o (w_any_found),
    .idx_o   (w_any_idx)
  );

  priority_encoder #(.N(PORTS), .LSB_HIGH(LSB_HIGH)) u_pe_masked (
    .req_i   (s_axis_tvalid & mask_q),
    .found_o (w_msk_found),
    .idx_o   (w_msk_idx)
  );

  // Masked requesters win first; fall back to the full set when the mask
  // leaves nobody (wrap-around of the round-robin pointer).
  assign w_win_idx = w_msk_found ? w_msk_idx : w_any_idx;

  // The output register can take a beat when empty or draining this cycle.
  assign w_out_ready   = !m_tvalid_q || m_axis_tready;
  // grant_q is all-zero in IDLE, so no ready bit can rise there.
  assign s_axis_tready = grant_q & {PORTS{w_out_ready}};
  assign w_accept      = |(s_axis_tvalid & s_axis_tready);
  assign w_accept_last = w_accept && s_axis_tlast[grant_idx_q];

  // Next mask: ports strictly after the finishing grant in priority order.
  always_comb begin
    mask_d = mask_q;
    if (ROUND_ROBIN) begin
      for (int i = 0; i < PORTS; i++) begin
        mask_d[i] = LSB_HIGH ? (i > int'(grant_idx_q)) : (i < int'(grant_idx_q));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      mask_q      <= '1;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tid_q     <= '0;
    end else begin
      // Output register: a load wins over a drain in the same cycle.
      if (w_accept) begin
        m_tdata_q  <= w_data[grant_idx_q];
        m_tlast_q  <= s_axis_tlast[grant_idx_q];
        m_tid_q    <= grant_idx_q;
        m_tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (w_any_found) begin
            grant_q     <= c_one << w_win_idx;
            grant_idx_q <= w_win_idx;
            state_q     <= LOCK;
          end
        end
        LOCK: begin
          if (w_accept_last) begin
            grant_q <= '0;
            mask_q  <= mask_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign busy          = (state_q == LOCK);

endmodule
`default_nettype wire
